// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: CP0 op encodings, register numbers, ExcCodes,
// Status/Cause bit positions and the exception-control FSM state type.
package cp0_pkg;

  // CP0 operation encodings carried down the pipeline
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MFC0 = 3'b001;
  localparam logic [2:0] OP_MTC0 = 3'b010;
  localparam logic [2:0] OP_ERET = 3'b100;

  // CP0 register numbers (all at sel 0)
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Status / Cause field positions
  localparam int unsigned ST_IE     = 0;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_IM_LO  = 8;
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_IP_LO  = 8;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_DRAIN    = 2'd2
  } fsm_t;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky match flag.
// Ports: clk, rst (async, active-high); wr_count / wr_compare qualified MTC0
// strobes with wr_data; count, compare register values; timer_flag sticky
// match indication (cleared by an MTC0 to Compare).
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_flag
);

  logic toggle;

  // Count advances on every second clock; software writes win over the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle     <= 1'b0;
      count      <= '0;
      compare    <= '0;
      timer_flag <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (wr_count)
        count <= wr_data;
      else if (toggle)
        count <= count + 32'd1;
      if (wr_compare)
        compare <= wr_data;
      // Clearing via Compare write takes precedence over a same-edge match
      if (wr_compare)
        timer_flag <= 1'b0;
      else if (count == compare)
        timer_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and exception/interrupt/ERET sequencer.
// Owns Count, Compare, Status, Cause and EPC; samples MEM-stage events,
// commits WB-stage MTC0 writes, serves the ID-stage MFC0 read (rd_data,
// combinational, no internal bypass) and emits a one-cycle registered
// redirect_valid/flush pulse followed by a DRAIN window (busy high).
// Ports: clk, rst (async active-high); mem_* MEM-stage event inputs;
// wr_* WB-stage MTC0; rd_cs/rd_sel/rd_data MFC0 read; hw_int level
// interrupts; redirect_valid/redirect_pc/flush redirect; epc_o; busy.
// Optional feature macro: CP0_TIMER_EN enables the Count/Compare timer.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_exc_valid,
  input  logic [4:0]  mem_exc_code,
  input  logic [2:0]  mem_cp0op,
  input  logic [2:0]  wr_cp0op,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_cs,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic [5:0]  hw_int,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] epc_o,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;

  fsm_t             state, state_nxt;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic             status_ie, status_ie_nxt;
  logic             status_exl, status_exl_nxt;
  logic [7:0]       status_im, status_im_nxt;
  logic [4:0]       cause_exc, cause_exc_nxt;
  logic [1:0]       cause_ip_sw, cause_ip_sw_nxt;
  logic [31:0]      epc_q, epc_nxt;
  logic [31:0]      redirect_pc_nxt;
  logic             redirect_valid_nxt, flush_nxt, busy_nxt;

  logic        wr_en;
  logic        timer_flag;
  logic [31:0] count_val, compare_val;
  logic [7:0]  ip;
  logic        int_pend;
  logic [31:0] status_word, cause_word;

  assign wr_en = (wr_cp0op == OP_MTC0) && (wr_sel == 3'd0);

`ifdef CP0_TIMER_EN
  logic wr_count, wr_compare;
  assign wr_count   = wr_en && (wr_cs == REG_COUNT);
  assign wr_compare = wr_en && (wr_cs == REG_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count),
    .wr_compare (wr_compare),
    .wr_data    (wr_data),
    .count      (count_val),
    .compare    (compare_val),
    .timer_flag (timer_flag)
  );
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign timer_flag  = 1'b0;
`endif

  // IP[7:2] follow the hardware lines live; IP[7] also carries the timer
  assign ip       = {hw_int[5] | timer_flag, hw_int[4:0], cause_ip_sw};
  assign int_pend = status_ie & ~status_exl & (|(ip & status_im)) & mem_valid;

  assign status_word = {16'h0, status_im, 6'h0, status_exl, status_ie};
  assign cause_word  = {16'h0, ip, 1'b0, cause_exc, 2'b00};
  assign epc_o       = epc_q;

  // MFC0 read port: pre-edge register values, undefined cs/sel read zero
  always_comb begin
    rd_data = '0;
    if (rd_sel == 3'd0) begin
      case (rd_cs)
        REG_COUNT:   rd_data = count_val;
        REG_COMPARE: rd_data = compare_val;
        REG_STATUS:  rd_data = status_word;
        REG_CAUSE:   rd_data = cause_word;
        REG_EPC:     rd_data = epc_q;
        default:     rd_data = '0;
      endcase
    end
  end

  // Next-state: MTC0 applied first, then a taken event overwrites its own fields
  always_comb begin
    state_nxt          = state;
    drain_cnt_nxt      = drain_cnt;
    status_ie_nxt      = status_ie;
    status_exl_nxt     = status_exl;
    status_im_nxt      = status_im;
    cause_exc_nxt      = cause_exc;
    cause_ip_sw_nxt    = cause_ip_sw;
    epc_nxt            = epc_q;
    redirect_pc_nxt    = redirect_pc;
    redirect_valid_nxt = 1'b0;
    flush_nxt          = 1'b0;
    busy_nxt           = 1'b0;

    if (wr_en) begin
      case (wr_cs)
        REG_STATUS: begin
          status_ie_nxt  = wr_data[ST_IE];
          status_exl_nxt = wr_data[ST_EXL];
          status_im_nxt  = wr_data[ST_IM_LO +: 8];
        end
        REG_CAUSE: cause_ip_sw_nxt = wr_data[CA_IP_LO +: 2];
        REG_EPC:   epc_nxt         = wr_data;
        default:   ;
      endcase
    end

    case (state)
      S_RUN: begin
        if (int_pend) begin
          epc_nxt         = mem_pc;
          cause_exc_nxt   = EXC_INT;
          status_exl_nxt  = 1'b1;
          redirect_pc_nxt = EXC_VECTOR;
          state_nxt       = S_REDIRECT;
        end else if (mem_exc_valid && mem_valid) begin
          epc_nxt         = mem_pc;
          cause_exc_nxt   = mem_exc_code;
          status_exl_nxt  = 1'b1;
          redirect_pc_nxt = EXC_VECTOR;
          state_nxt       = S_REDIRECT;
        end else if ((mem_cp0op == OP_ERET) && mem_valid) begin
          status_exl_nxt  = 1'b0;
          redirect_pc_nxt = epc_q;
          state_nxt       = S_REDIRECT;
        end
        if (state_nxt == S_REDIRECT) begin
          redirect_valid_nxt = 1'b1;
          flush_nxt          = 1'b1;
          busy_nxt           = 1'b1;
        end
      end
      S_REDIRECT: begin
        state_nxt     = S_DRAIN;
        drain_cnt_nxt = CNT_W'(DRAIN_CYCLES - 1);
        busy_nxt      = 1'b1;
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = S_RUN;
        end else begin
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
          busy_nxt      = 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // State, architectural registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_RUN;
      drain_cnt      <= '0;
      status_ie      <= 1'b0;
      status_exl     <= 1'b0;
      status_im      <= '0;
      cause_exc      <= '0;
      cause_ip_sw    <= '0;
      epc_q          <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      drain_cnt      <= drain_cnt_nxt;
      status_ie      <= status_ie_nxt;
      status_exl     <= status_exl_nxt;
      status_im      <= status_im_nxt;
      cause_exc      <= cause_exc_nxt;
      cause_ip_sw    <= cause_ip_sw_nxt;
      epc_q          <= epc_nxt;
      redirect_pc    <= redirect_pc_nxt;
      redirect_valid <= redirect_valid_nxt;
      flush          <= flush_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: table of per-cycle vectors with
// hand-computed expectations, plus sequences for read-select, async reset
// mid-redirect and (with CP0_TIMER_EN) the Count/Compare interrupt.
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_exc_valid;
  logic [4:0]  mem_exc_code;
  logic [2:0]  mem_cp0op;
  logic [2:0]  wr_cp0op;
  logic [4:0]  wr_cs;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rd_cs;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [5:0]  hw_int;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] epc_o;
  logic        busy;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_exc_valid  (mem_exc_valid),
    .mem_exc_code   (mem_exc_code),
    .mem_cp0op      (mem_cp0op),
    .wr_cp0op       (wr_cp0op),
    .wr_cs          (wr_cs),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .rd_cs          (rd_cs),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .hw_int         (hw_int),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .epc_o          (epc_o),
    .busy           (busy)
  );

  typedef struct {
    logic        mv;
    logic [31:0] pc;
    logic        ev;
    logic [4:0]  code;
    logic [2:0]  mop;
    logic [2:0]  wop;
    logic [4:0]  wcs;
    logic [31:0] wd;
    logic [4:0]  rcs;
    logic [5:0]  hw;
    logic [2:0]  ctl;   // {redirect_valid, flush, busy} after the edge
    logic [31:0] rpc;
    logic [31:0] rd;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic mv, input logic [31:0] pc, input logic ev,
                              input logic [4:0] code, input logic [2:0] mop,
                              input logic [2:0] wop, input logic [4:0] wcs,
                              input logic [31:0] wd, input logic [4:0] rcs,
                              input logic [5:0] hw, input logic [2:0] ctl,
                              input logic [31:0] rpc, input logic [31:0] rd,
                              input logic [31:0] epc);
    vec_t v;
    v.mv = mv; v.pc = pc; v.ev = ev; v.code = code; v.mop = mop;
    v.wop = wop; v.wcs = wcs; v.wd = wd; v.rcs = rcs; v.hw = hw;
    v.ctl = ctl; v.rpc = rpc; v.rd = rd; v.epc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_pc = '0; mem_exc_valid = 1'b0; mem_exc_code = '0;
    mem_cp0op = OP_NOP; wr_cp0op = OP_NOP; wr_cs = '0; wr_sel = '0;
    wr_data = '0; rd_cs = REG_STATUS; rd_sel = '0; hw_int = '0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic mtc0(input logic [4:0] cs, input logic [31:0] d);
    wr_cp0op = OP_MTC0; wr_cs = cs; wr_data = d;
    @(posedge clk); #1;
    wr_cp0op = OP_NOP;
  endtask
`endif

  initial begin
    logic [2:0] ctl;
    localparam logic [2:0] N = OP_NOP;
    localparam logic [2:0] M = OP_MTC0;
    localparam logic [2:0] E = OP_ERET;

    //          mv pc            ev code mop wop wcs         wd            rcs         hw  ctl     rpc           rd            epc
    vecs[0]  = mk(1, 32'h8000_0100, 1, 8,  N, N, 5'd0,       32'h0,        REG_CAUSE,  0, 3'b111, VEC,          32'h20,       32'h8000_0100);
    vecs[1]  = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, VEC,          32'h2,        32'h8000_0100);
    vecs[2]  = mk(1, 32'h8000_0200, 1, 10, N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, VEC,          32'h2,        32'h8000_0100);
    vecs[3]  = mk(1, 32'h8000_0200, 1, 10, N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b000, VEC,          32'h2,        32'h8000_0100);
    vecs[4]  = mk(1, 32'h8000_0200, 1, 10, N, N, 5'd0,       32'h0,        REG_CAUSE,  0, 3'b111, VEC,          32'h28,       32'h8000_0200);
    vecs[5]  = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_EPC,    0, 3'b001, VEC,          32'h8000_0200, 32'h8000_0200);
    vecs[6]  = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, VEC,          32'h2,        32'h8000_0200);
    vecs[7]  = mk(0, 32'h0,         0, 0,  N, M, REG_EPC,    32'h8000_0104, REG_EPC,   0, 3'b000, VEC,          32'h8000_0104, 32'h8000_0104);
    vecs[8]  = mk(1, 32'h8000_0300, 0, 0,  E, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b111, 32'h8000_0104, 32'h0,       32'h8000_0104);
    vecs[9]  = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, 32'h8000_0104, 32'h0,       32'h8000_0104);
    vecs[10] = mk(0, 32'h0,         0, 0,  N, M, REG_STATUS, 32'h401,      REG_STATUS, 0, 3'b001, 32'h8000_0104, 32'h401,     32'h8000_0104);
    vecs[11] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_CAUSE,  1, 3'b000, 32'h8000_0104, 32'h428,     32'h8000_0104);
    vecs[12] = mk(1, 32'h8000_0400, 0, 0,  N, N, 5'd0,       32'h0,        REG_CAUSE,  1, 3'b111, VEC,          32'h400,      32'h8000_0400);
    vecs[13] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, VEC,          32'h403,      32'h8000_0400);
    vecs[14] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b001, VEC,          32'h403,      32'h8000_0400);
    vecs[15] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 0, 3'b000, VEC,          32'h403,      32'h8000_0400);
    vecs[16] = mk(1, 32'h8000_0500, 0, 0,  N, N, 5'd0,       32'h0,        REG_STATUS, 1, 3'b000, VEC,          32'h403,      32'h8000_0400);
    vecs[17] = mk(1, 32'h8000_0600, 1, 12, N, M, REG_STATUS, 32'hFF01,     REG_STATUS, 0, 3'b111, VEC,          32'hFF03,     32'h8000_0600);
    vecs[18] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        REG_CAUSE,  0, 3'b001, VEC,          32'h30,       32'h8000_0600);
    vecs[19] = mk(0, 32'h0,         0, 0,  N, N, 5'd0,       32'h0,        5'd3,       0, 3'b001, VEC,          32'h0,        32'h8000_0600);
    vecs[20] = mk(0, 32'h0,         0, 0,  N, M, REG_CAUSE,  32'h37C,      REG_CAUSE,  0, 3'b000, VEC,          32'h330,      32'h8000_0600);
    vecs[21] = mk(0, 32'h0,         0, 0,  N, M, REG_STATUS, 32'hFFFF_FFFD, REG_STATUS, 0, 3'b000, VEC,         32'hFF01,     32'h8000_0600);
    vecs[22] = mk(1, 32'h8000_0700, 0, 0,  N, N, 5'd0,       32'h0,        REG_CAUSE,  0, 3'b111, VEC,          32'h300,      32'h8000_0700);

    idle_inputs();
    rst = 1'b1;
    #11;
    ctl = {redirect_valid, flush, busy};
    check("reset_ctl", 32'(ctl), 32'h0);
    check("reset_redirect_pc", redirect_pc, 32'h0);
    check("reset_epc", epc_o, 32'h0);
    check("reset_status", rd_data, 32'h0);
    #1 rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      mem_valid = vecs[i].mv;  mem_pc = vecs[i].pc;
      mem_exc_valid = vecs[i].ev; mem_exc_code = vecs[i].code;
      mem_cp0op = vecs[i].mop; wr_cp0op = vecs[i].wop;
      wr_cs = vecs[i].wcs; wr_sel = 3'd0; wr_data = vecs[i].wd;
      rd_cs = vecs[i].rcs; rd_sel = 3'd0; hw_int = vecs[i].hw;
      @(posedge clk); #1;
      ctl = {redirect_valid, flush, busy};
      check($sformatf("row%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      check($sformatf("row%0d_redirect_pc", i), redirect_pc, vecs[i].rpc);
      check($sformatf("row%0d_rd_data", i), rd_data, vecs[i].rd);
      check($sformatf("row%0d_epc", i), epc_o, vecs[i].epc);
    end

    // Non-zero select reads zero even though Status is non-zero (EXL set)
    idle_inputs();
    rd_cs = REG_STATUS; rd_sel = 3'd1;
    #1;
    check("sel1_read", rd_data, 32'h0);
    rd_sel = 3'd0;
    #1;
    check("sel0_read", rd_data, 32'hFF03);

    // Asynchronous reset while in REDIRECT
    rst = 1'b1;
    #1;
    ctl = {redirect_valid, flush, busy};
    check("midreset_ctl", 32'(ctl), 32'h0);
    check("midreset_redirect_pc", redirect_pc, 32'h0);
    check("midreset_epc", epc_o, 32'h0);
    check("midreset_status", rd_data, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    ctl = {redirect_valid, flush, busy};
    check("post_reset_ctl", 32'(ctl), 32'h0);

`ifdef CP0_TIMER_EN
    begin
      int n;
      bit seen;
      mtc0(REG_STATUS, 32'h8001);
      mtc0(REG_COMPARE, 32'd10);
      mtc0(REG_COUNT, 32'd0);
      mem_valid = 1'b1; mem_pc = 32'h8000_0800;
      seen = 1'b0; n = 0;
      for (int c = 1; c <= 40 && !seen; c++) begin
        @(posedge clk); #1;
        if (redirect_valid) begin
          seen = 1'b1; n = c;
        end
      end
      check("timer_irq_seen", 32'(seen), 32'd1);
      check("timer_irq_latency_ok", 32'(n >= 15 && n <= 25), 32'd1);
      check("timer_epc", epc_o, 32'h8000_0800);
      mem_valid = 1'b0;
      rd_cs = REG_CAUSE;
      #1;
      check("timer_ip7_set", 32'(rd_data[15]), 32'd1);
      mtc0(REG_COMPARE, 32'd100);
      check("timer_ip7_cleared", 32'(rd_data[15]), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
